micro_sequencer: RTL and testbench

//  Microprogram sequencer: owns the control store address register (CSAR) and picks the next

---
 rtl/micro_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_micro_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// -----------------------------------------------------------------------------
// micro_sequencer
//   Microprogram sequencer. Owns the control store address register (CSAR)
//   and chooses the next microaddress every cycle. The choices are: next
//   sequential, conditional or unconditional jump, opcode decode, call and
//   return. The sequencer holds the CSAR while a memory access is
//   outstanding. A small LIFO keeps return addresses for microsubroutines.
//
// Ports
//   MICROSEQ_CLOCK_50           in   system clock, rising edge
//   MICROSEQ_ResetInLow_In      in   asynchronous reset, active low
//   MICROSEQ_Cond_InBus         in   3  000 next, 001 always, 010 N, 011 Z,
//                                       100 V, 101 C, 110 decode, 111 return
//   MICROSEQ_JumpAddress_InBus  in   jump target from the microword
//   MICROSEQ_Call_In            in   push CSAR+1 when a jump is taken
//   MICROSEQ_Flags_InBus        in   4  {N,Z,V,C}
//   MICROSEQ_DecodeOp_InBus     in   opcode from the instruction register
//   MICROSEQ_MemReq_In          in   current microword starts a memory access
//   MICROSEQ_MemReady_In        in   memory access complete
//   MICROSEQ_CSAddress_OutBus   out  CSAR (registered)
//   MICROSEQ_Stall_Out          out  CSAR held waiting for memory
//   MICROSEQ_StackErr_Out       out  sticky stack overflow/underflow flag
// -----------------------------------------------------------------------------
module micro_sequencer #(
  parameter int DATAWIDTH_CSADDRESS = 11,
  parameter int DATAWIDTH_OPS       = 8,
  parameter int STACK_DEPTH         = 4,
  parameter logic [DATAWIDTH_CSADDRESS-1:0] RESET_VECTOR = 11'h000,
  parameter logic [DATAWIDTH_CSADDRESS-1:0] FAULT_VECTOR = 11'h7F0
) (
  input  logic                           MICROSEQ_CLOCK_50,
  input  logic                           MICROSEQ_ResetInLow_In,
  input  logic [2:0]                     MICROSEQ_Cond_InBus,
  input  logic [DATAWIDTH_CSADDRESS-1:0] MICROSEQ_JumpAddress_InBus,
  input  logic                           MICROSEQ_Call_In,
  input  logic [3:0]                     MICROSEQ_Flags_InBus,
  input  logic [DATAWIDTH_OPS-1:0]       MICROSEQ_DecodeOp_InBus,
  input  logic                           MICROSEQ_MemReq_In,
  input  logic                           MICROSEQ_MemReady_In,
  output logic [DATAWIDTH_CSADDRESS-1:0] MICROSEQ_CSAddress_OutBus,
  output logic                           MICROSEQ_Stall_Out,
  output logic                           MICROSEQ_StackErr_Out
);

  localparam int AW    = DATAWIDTH_CSADDRESS;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   csar_q, csar_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic            err_q, err_d;

  // The return stack is only a few entries deep. It uses an asynchronous
  // read so that a return can complete in one cycle. The stack therefore
  // maps to registers, not block RAM.
  logic [AW-1:0]    stack_mem [0:(1 << IDX_W)-1];
  logic [IDX_W-1:0] push_idx, pop_idx;

  logic [AW-1:0] inc_addr, decode_addr, next_addr, stack_top;
  logic          cond_true, push_req, pop_req, stack_err;
  logic          apply, push_en, stall;

  assign inc_addr  = csar_q + AW'(1);
  assign push_idx  = IDX_W'(sp_q);
  assign pop_idx   = IDX_W'(sp_q - SP_W'(1));
  assign stack_top = stack_mem[pop_idx];

  // Opcodes with the top two bits equal to 00 are grouped into 32-word
  // blocks. All other opcodes each get a 4-word slot.
  // Both forms set the MSB, so decode targets land in the upper half.
  assign decode_addr = (MICROSEQ_DecodeOp_InBus[7:6] == 2'b00) ?
                       {1'b1, MICROSEQ_DecodeOp_InBus[7:3], 5'b0} :
                       {1'b1, MICROSEQ_DecodeOp_InBus[7:0], 2'b0};

  // Next-address decision. It uses the microword and flags that are
  // present this cycle.
  always_comb begin
    cond_true = 1'b0;
    next_addr = inc_addr;
    push_req  = 1'b0;
    pop_req   = 1'b0;
    stack_err = 1'b0;
    case (MICROSEQ_Cond_InBus)
      3'b001:  cond_true = 1'b1;
      3'b010:  cond_true = MICROSEQ_Flags_InBus[3];
      3'b011:  cond_true = MICROSEQ_Flags_InBus[2];
      3'b100:  cond_true = MICROSEQ_Flags_InBus[1];
      3'b101:  cond_true = MICROSEQ_Flags_InBus[0];
      default: cond_true = 1'b0;
    endcase
    case (MICROSEQ_Cond_InBus)
      3'b000: next_addr = inc_addr;
      3'b110: next_addr = decode_addr;
      3'b111: begin
        if (sp_q == '0) stack_err = 1'b1;
        else begin
          next_addr = stack_top;
          pop_req   = 1'b1;
        end
      end
      default: begin
        if (cond_true) begin
          next_addr = MICROSEQ_JumpAddress_InBus;
          if (MICROSEQ_Call_In) begin
            if (sp_q == SP_FULL) stack_err = 1'b1;
            else                 push_req  = 1'b1;
          end
        end
      end
    endcase
    if (stack_err) next_addr = FAULT_VECTOR;
  end

  // Control FSM. The FAULT state marks the cycle in which the fault vector
  // was loaded. Apart from that, FAULT behaves exactly like RUN.
  always_comb begin
    state_d = state_q;
    csar_d  = csar_q;
    sp_d    = sp_q;
    err_d   = err_q;
    apply   = 1'b0;
    stall   = 1'b0;
    push_en = 1'b0;
    case (state_q)
      ST_WAIT_MEM: begin
        stall = 1'b1;
        if (MICROSEQ_MemReady_In) apply = 1'b1;
      end
      default: begin
        if (MICROSEQ_MemReq_In && !MICROSEQ_MemReady_In) begin
          stall   = 1'b1;
          state_d = ST_WAIT_MEM;
        end else begin
          apply = 1'b1;
        end
      end
    endcase
    if (apply) begin
      csar_d = next_addr;
      if (stack_err) begin
        state_d = ST_FAULT;
        err_d   = 1'b1;
      end else begin
        state_d = ST_RUN;
        if (push_req) begin
          push_en = 1'b1;
          sp_d    = sp_q + SP_W'(1);
        end else if (pop_req) begin
          sp_d = sp_q - SP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge MICROSEQ_CLOCK_50 or negedge MICROSEQ_ResetInLow_In) begin
    if (!MICROSEQ_ResetInLow_In) begin
      state_q <= ST_RUN;
      csar_q  <= RESET_VECTOR;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      csar_q  <= csar_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  // Stack contents are not reset. Only SP tracks validity.
  always_ff @(posedge MICROSEQ_CLOCK_50) begin
    if (push_en) stack_mem[push_idx] <= inc_addr;
  end

  assign MICROSEQ_CSAddress_OutBus = csar_q;
  assign MICROSEQ_StackErr_Out     = err_q;
  // Stall is combinational from MemReq. It is masked while reset is held.
  assign MICROSEQ_Stall_Out        = stall & MICROSEQ_ResetInLow_In;

endmodule

// File: tb/tb_micro_sequencer.sv
// -----------------------------------------------------------------------------
// tb_micro_sequencer
//   Directed, table-driven bench for micro_sequencer. It also has hand-written
//   sequences for the memory-wait and reset-during-wait cases.
// -----------------------------------------------------------------------------
module tb_micro_sequencer;

  logic        clk;
  logic        rst_n;
  logic [2:0]  cond;
  logic [10:0] jump;
  logic        call;
  logic [3:0]  flags;
  logic [7:0]  op;
  logic        mreq;
  logic        mrdy;
  logic [10:0] csar;
  logic        stall;
  logic        serr;

  int errors = 0;
  int checks = 0;

  micro_sequencer dut (
    .MICROSEQ_CLOCK_50          (clk),
    .MICROSEQ_ResetInLow_In     (rst_n),
    .MICROSEQ_Cond_InBus        (cond),
    .MICROSEQ_JumpAddress_InBus (jump),
    .MICROSEQ_Call_In           (call),
    .MICROSEQ_Flags_InBus       (flags),
    .MICROSEQ_DecodeOp_InBus    (op),
    .MICROSEQ_MemReq_In         (mreq),
    .MICROSEQ_MemReady_In       (mrdy),
    .MICROSEQ_CSAddress_OutBus  (csar),
    .MICROSEQ_Stall_Out         (stall),
    .MICROSEQ_StackErr_Out      (serr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  c;
    logic [10:0] j;
    logic        cl;
    logic [3:0]  f;
    logic [7:0]  o;
    logic        mq;
    logic        mr;
    logic        es;
    logic [10:0] ec;
    logic        ee;
  } vec_t;

  localparam int NVEC = 30;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [2:0] c, input logic [10:0] j, input logic cl,
                              input logic [3:0] f, input logic [7:0] o, input logic mq,
                              input logic mr, input logic es, input logic [10:0] ec,
                              input logic ee);
    vec_t v;
    v.c = c; v.j = j; v.cl = cl; v.f = f; v.o = o;
    v.mq = mq; v.mr = mr; v.es = es; v.ec = ec; v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] c, input logic [10:0] j, input logic cl,
                       input logic [3:0] f, input logic [7:0] o, input logic mq,
                       input logic mr);
    cond = c; jump = j; call = cl; flags = f; op = o; mreq = mq; mrdy = mr;
  endtask

  // Called shortly after a rising edge. The task checks combinational stall
  // for the current inputs, advances one clock, then checks the registered
  // outputs.
  task automatic cycle(input string tag, input logic es, input logic [10:0] ec,
                       input logic ee);
    #1;
    chk({tag, " stall"}, 32'(stall), 32'(es));
    @(posedge clk);
    #1;
    chk({tag, " csar"}, 32'(csar), 32'(ec));
    chk({tag, " stackerr"}, 32'(serr), 32'(ee));
    $display("%s: cond=%b mreq=%b mrdy=%b -> csar=0x%03h stall=%b err=%b",
             tag, cond, mreq, mrdy, csar, stall, serr);
  endtask

  initial begin
    //                c     jump    cl f        op     mq mr es exp     ee
    vecs[0]  = mk(3'd0, 11'h000, 0, 4'b0000, 8'h00, 0, 0, 0, 11'h001, 0);
    vecs[1]  = mk(3'd0, 11'h000, 0, 4'b0000, 8'h00, 0, 0, 0, 11'h002, 0);
    vecs[2]  = mk(3'd0, 11'h000, 0, 4'b0000, 8'h00, 0, 0, 0, 11'h003, 0);
    vecs[3]  = mk(3'd3, 11'h120, 0, 4'b0100, 8'h00, 0, 0, 0, 11'h120, 0);
    vecs[4]  = mk(3'd3, 11'h155, 0, 4'b0000, 8'h00, 0, 0, 0, 11'h121, 0);
    vecs[5]  = mk(3'd1, 11'h120, 0, 4'b0000, 8'h00, 0, 0, 0, 11'h120, 0);
    vecs[6]  = mk(3'd2, 11'h300, 0, 4'b1000, 8'h00, 0, 0, 0, 11'h300, 0);
    vecs[7]  = mk(3'd4, 11'h100, 0, 4'b1101, 8'h00, 0, 0, 0, 11'h301, 0);
    vecs[8]  = mk(3'd5, 11'h010, 0, 4'b0001, 8'h00, 0, 0, 0, 11'h010, 0);
    vecs[9]  = mk(3'd1, 11'h200, 1, 4'b0000, 8'h00, 0, 0, 0, 11'h200, 0);
    vecs[10] = mk(3'd0, 11'h000, 0, 4'b0000, 8'h00, 0, 0, 0, 11'h201, 0);
    vecs[11] = mk(3'd3, 11'h400, 1, 4'b0000, 8'h00, 0, 0, 0, 11'h202, 0);
    vecs[12] = mk(3'd0, 11'h400, 1, 4'b0000, 8'h00, 0, 0, 0, 11'h203, 0);
    vecs[13] = mk(3'd7, 11'h000, 0, 4'b0000, 8'h00, 0, 0, 0, 11'h011, 0);
    vecs[14] = mk(3'd6, 11'h000, 0, 4'b0000, 8'h2A, 0, 0, 0, 11'h4A0, 0);
    vecs[15] = mk(3'd6, 11'h000, 0, 4'b0000, 8'hC3, 0, 0, 0, 11'h70C, 0);
    vecs[16] = mk(3'd1, 11'h7FF, 0, 4'b0000, 8'h00, 0, 0, 0, 11'h7FF, 0);
    vecs[17] = mk(3'd0, 11'h000, 0, 4'b0000, 8'h00, 0, 0, 0, 11'h000, 0);
    vecs[18] = mk(3'd1, 11'h005, 0, 4'b0000, 8'h00, 0, 0, 0, 11'h005, 0);
    vecs[19] = mk(3'd0, 11'h000, 0, 4'b0000, 8'h00, 1, 1, 0, 11'h006, 0);
    vecs[20] = mk(3'd1, 11'h100, 1, 4'b0000, 8'h00, 0, 0, 0, 11'h100, 0);
    vecs[21] = mk(3'd1, 11'h110, 1, 4'b0000, 8'h00, 0, 0, 0, 11'h110, 0);
    vecs[22] = mk(3'd1, 11'h120, 1, 4'b0000, 8'h00, 0, 0, 0, 11'h120, 0);
    vecs[23] = mk(3'd1, 11'h130, 1, 4'b0000, 8'h00, 0, 0, 0, 11'h130, 0);
    vecs[24] = mk(3'd1, 11'h140, 1, 4'b0000, 8'h00, 0, 0, 0, 11'h7F0, 1);
    vecs[25] = mk(3'd7, 11'h000, 0, 4'b0000, 8'h00, 0, 0, 0, 11'h121, 1);
    vecs[26] = mk(3'd7, 11'h000, 0, 4'b0000, 8'h00, 0, 0, 0, 11'h111, 1);
    vecs[27] = mk(3'd7, 11'h000, 0, 4'b0000, 8'h00, 0, 0, 0, 11'h101, 1);
    vecs[28] = mk(3'd7, 11'h000, 0, 4'b0000, 8'h00, 0, 0, 0, 11'h007, 1);
    vecs[29] = mk(3'd7, 11'h000, 0, 4'b0000, 8'h00, 0, 0, 0, 11'h7F0, 1);

    // Reset. MemReq is held high with MemReady low, so stall must be
    // masked by reset.
    rst_n = 1'b0;
    drive(3'd0, 11'h000, 1'b0, 4'b0000, 8'h00, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset csar", 32'(csar), 32'h000);
    chk("reset stall", 32'(stall), 32'h0);
    chk("reset stackerr", 32'(serr), 32'h0);
    $display("reset: csar=0x%03h stall=%b err=%b", csar, stall, serr);
    mreq  = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].c, vecs[i].j, vecs[i].cl, vecs[i].f, vecs[i].o, vecs[i].mq, vecs[i].mr);
      cycle($sformatf("vec%0d", i), vecs[i].es, vecs[i].ec, vecs[i].ee);
    end

    // Reset clears the sticky error flag.
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset2 csar", 32'(csar), 32'h000);
    chk("reset2 stackerr", 32'(serr), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Memory wait: CSAR is held at 0x005 for 3 cycles, then advances on ready.
    drive(3'd1, 11'h005, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b0);
    cycle("goto5", 1'b0, 11'h005, 1'b0);
    drive(3'd0, 11'h000, 1'b0, 4'b0000, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cycle($sformatf("wait%0d", k), 1'b1, 11'h005, 1'b0);
    mrdy = 1'b1;
    cycle("ready", 1'b1, 11'h006, 1'b0);
    drive(3'd0, 11'h000, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b0);
    cycle("after", 1'b0, 11'h007, 1'b0);

    // The decision is taken from the inputs present in the ready cycle.
    drive(3'd0, 11'h000, 1'b0, 4'b0000, 8'h00, 1'b1, 1'b0);
    cycle("wait_b", 1'b1, 11'h007, 1'b0);
    drive(3'd1, 11'h155, 1'b0, 4'b0000, 8'h00, 1'b0, 1'b1);
    cycle("ready_jump", 1'b1, 11'h155, 1'b0);

    // Reset during a wait drops the pending access.
    drive(3'd0, 11'h000, 1'b0, 4'b0000, 8'h00, 1'b1, 1'b0);
    cycle("wait_c", 1'b1, 11'h155, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midwait reset csar", 32'(csar), 32'h000);
    chk("midwait reset stall", 32'(stall), 32'h0);
    $display("midwait reset: csar=0x%03h stall=%b", csar, stall);
    mreq = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle("post_reset", 1'b0, 11'h001, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
